// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and column priority encoder for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int ROW_W  = 2;
   localparam int COL_W  = 2;
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HOLD,
      ST_RELEASE
   } state_t;

   // Returns {hit, col}: hit is set when any active-low column is low, col is the lowest such index.
   function automatic logic [COL_W:0] prio_enc(input logic [COLS-1:0] cols_n);
      logic [COL_W:0] r;
      r = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (!cols_n[c]) r = {1'b1, COL_W'(c)};
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous active-low column lines; idles high (no key).
module keypad_sync
   import keypad_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [COLS-1:0] d_i,
   output logic [COLS-1:0] q_o
);

   logic [COLS-1:0] meta_q;
   logic [COLS-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, column debounce, priority encode, one-cycle valid strobe.
// Optional auto-repeat while a key is held: define KEYPAD_SCANNER_KEY_REPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [COLS-1:0]   col_n,
   output logic [ROW_W-1:0]  row_sel,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scanner: illegal parameter value");
   end

   logic [COLS-1:0]   col_s;
   logic [COL_W:0]    enc;
   logic              hit;
   logic [COL_W-1:0]  hit_col;
   logic              cand_act;
   logic              tick;
   logic [ROW_W-1:0]  row_nxt;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              held_q, held_d;

`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   logic [REP_W-1:0]  rep_q, rep_d, rep_nxt;
   logic              rep_arm_q, rep_arm_d;
`endif

   keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (col_n),
      .q_o   (col_s)
   );

   assign enc      = prio_enc(col_s);
   assign hit      = enc[COL_W];
   assign hit_col  = enc[COL_W-1:0];
   assign cand_act = !col_s[cand_q[COL_W-1:0]];
   assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
   assign row_nxt  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
   assign cnt_inc  = cnt_q + CNT_W'(1);

   // Divider restarts with every row change so each row gets the full settle time.
   assign div_d = (tick || (row_d != row_q)) ? '0 : div_q + DIV_W'(1);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      valid_d = 1'b0;
      held_d  = held_q;
`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
      rep_d     = rep_q;
      rep_arm_d = rep_arm_q;
      rep_nxt   = rep_q + REP_W'(1);
`endif
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (!hit) begin
                  row_d = row_nxt;
               end else begin
                  cand_d = {row_q, hit_col};
                  cnt_d  = CNT_W'(1);
                  if (DEBOUNCE == 1) begin
                     code_d  = {row_q, hit_col};
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                     state_d = ST_HOLD;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (hit && (hit_col == cand_q[COL_W-1:0])) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                     state_d = ST_HOLD;
`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
                     rep_d     = '0;
                     rep_arm_d = 1'b0;
`endif
                  end
               end else begin
                  cnt_d   = '0;
                  row_d   = row_nxt;
                  state_d = ST_SCAN;
               end
            end
            ST_HOLD: begin
               if (!cand_act) begin
`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
                  rep_d     = '0;
                  rep_arm_d = 1'b0;
`endif
                  if (DEBOUNCE == 1) begin
                     cnt_d   = '0;
                     held_d  = 1'b0;
                     row_d   = row_nxt;
                     state_d = ST_SCAN;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = ST_RELEASE;
                  end
               end else begin
`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
                  // First repeat after REPEAT_DELAY held ticks, then one every REPEAT_RATE.
                  if ((!rep_arm_q && rep_nxt == REP_W'(REPEAT_DELAY)) ||
                      (rep_arm_q && rep_nxt == REP_W'(REPEAT_RATE))) begin
                     valid_d   = 1'b1;
                     rep_d     = '0;
                     rep_arm_d = 1'b1;
                  end else begin
                     rep_d = rep_nxt;
                  end
`endif
               end
            end
            ST_RELEASE: begin
               if (!cand_act) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                     cnt_d   = '0;
                     held_d  = 1'b0;
                     row_d   = row_nxt;
                     state_d = ST_SCAN;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SCAN;
         row_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q     <= '0;
         rep_arm_q <= 1'b0;
      end else begin
         rep_q     <= rep_d;
         rep_arm_q <= rep_arm_d;
      end
   end
`endif

   assign row_sel   = row_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 and a behavioural keypad model.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int LAT      = (DEB - 1) * SCAN_DIV + 1 + (SCAN_DIV - 1);

   typedef struct {
      logic [1:0] row;
      logic [3:0] cols;
      logic [3:0] code;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] col_n;
   logic [1:0] row_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [1:0] press_row  = 2'd0;
   logic [3:0] press_cols = 4'hF;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [3:0] exp_q[$];
   logic [3:0] sb_e;
   vec_t       vec[5];

   always #5 clk = ~clk;

   // Keypad model: the pressed key pulls its columns low only while its row is selected.
   assign col_n = (row_sel == press_row) ? press_cols : 4'hF;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE     (DEB),
      .REPEAT_DELAY (5),
      .REPEAT_RATE  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_n     (col_n),
      .row_sel   (row_sel),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_row(input logic [1:0] r, input string name);
      int k;
      k = 0;
      while (row_sel !== r && k < 100) begin
         step();
         k++;
      end
      if (row_sel !== r) chk({name, "_timeout"}, row_sel, r);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (key_valid !== 1'b1 && k < 60);
   endtask

   // Scoreboard: every strobe must match the next expected code.
   always @(negedge clk) begin
      if (rst_n && key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: actual key_code %0h, required no strobe", key_code);
         end else begin
            sb_e = exp_q.pop_front();
            chk("valid_code", key_code, sb_e);
            chk("valid_held", key_held, 1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      logic [1:0] tgt;
      logic [1:0] nxt;
      logic [1:0] prv;

      vec[0] = '{row: 2'd2, cols: 4'b1101, code: 4'h9};
      vec[1] = '{row: 2'd1, cols: 4'b0110, code: 4'h4};
      vec[2] = '{row: 2'd3, cols: 4'b0111, code: 4'hF};
      vec[3] = '{row: 2'd0, cols: 4'b1110, code: 4'h0};
      vec[4] = '{row: 2'd1, cols: 4'b1011, code: 4'h6};

      // Reset state and idle row scan
      rst_n = 1'b0;
      step(3);
      chk("rst_row", row_sel, 0);
      chk("rst_code", key_code, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("idle_row_seq", row_sel, (i / SCAN_DIV) % 4);
      end

      // Table-driven presses: latency, code, freeze, release debounce
      for (int i = 0; i < 5; i++) begin
         tgt = vec[i].row;
         prv = tgt - 2'd1;
         nxt = tgt + 2'd1;
         wait_row(prv, "pre_row");
         press_row  = tgt;
         press_cols = vec[i].cols;
         exp_q.push_back(vec[i].code);
         wait_row(tgt, "tgt_row");
         wait_valid(k);
         chk("press_latency", k, LAT);
         chk("press_code", key_code, vec[i].code);
         chk("press_row_frozen", row_sel, tgt);
         press_cols = 4'hF;
         step(8);
         chk("release_held_still", key_held, 1);
         chk("release_row_frozen", row_sel, tgt);
         step(4);
         chk("release_held_low", key_held, 0);
         chk("release_row_resume", row_sel, nxt);
      end

      // Bounce: key (1,3) seen on two ticks only
      wait_row(2'd0, "bounce_pre");
      press_row  = 2'd1;
      press_cols = 4'b0111;
      wait_row(2'd1, "bounce_row");
      step(8);
      chk("bounce_row_frozen", row_sel, 1);
      press_cols = 4'hF;
      step(3);
      chk("bounce_row_still", row_sel, 1);
      step(1);
      chk("bounce_row_resume", row_sel, 2);
      chk("bounce_code_kept", key_code, 4'h6);
      chk("bounce_held", key_held, 0);

      // Release glitch: key (3,2) re-pressed after one inactive tick
      wait_row(2'd2, "glitch_pre");
      press_row  = 2'd3;
      press_cols = 4'b1011;
      exp_q.push_back(4'hE);
      wait_row(2'd3, "glitch_row");
      wait_valid(k);
      chk("glitch_latency", k, LAT);
      press_cols = 4'hF;
      step(5);
      press_cols = 4'b1011;
      step(3);
      chk("glitch_held_a", key_held, 1);
      step(8);
      chk("glitch_held_b", key_held, 1);
      chk("glitch_row_frozen", row_sel, 3);
      press_cols = 4'hF;
      step(8);
      chk("glitch_release_held", key_held, 1);
      step(4);
      chk("glitch_release_done", key_held, 0);
      chk("glitch_row_resume", row_sel, 0);

`ifdef KEYPAD_SCANNER_KEY_REPEAT_EN
      // Auto-repeat: key (0,0) held 12 ticks -> strobes at acceptance and held ticks 5,7,9,11
      wait_row(2'd3, "rep_pre");
      press_row  = 2'd0;
      press_cols = 4'b1110;
      for (int i = 0; i < 5; i++) exp_q.push_back(4'h0);
      wait_row(2'd0, "rep_row");
      wait_valid(k);
      chk("rep_latency", k, LAT);
      step(45);
      press_cols = 4'hF;
      step(12);
      chk("rep_release_held", key_held, 0);
      chk("rep_all_strobes", exp_q.size(), 0);
`endif

      // Asynchronous reset in the middle of debounce of key (2,1)
      wait_row(2'd1, "mid_rst_pre");
      press_row  = 2'd2;
      press_cols = 4'b1101;
      wait_row(2'd2, "mid_rst_row");
      step(6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_row", row_sel, 0);
      chk("mid_rst_code", key_code, 0);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_held", key_held, 0);
      press_cols = 4'hF;
      step(2);
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("post_rst_row_seq", row_sel, (i / SCAN_DIV) % 4);
      end
      chk("post_rst_code", key_code, 0);

      step(4);
      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
